// File: rtl/sram_block_master.sv
`default_nettype none
// ============================================================================
// Module   : sram_block_master
// Purpose  : Initiator-side controller for the on-chip SRAM wrapper. Accepts
//            single or burst block commands from a client, sequences timed
//            SRAM accesses (each enable held WAIT_CYCLES cycles), streams
//            write blocks in and read blocks out over valid/ready handshakes,
//            and advances the byte address by DATA_BYTES per block (wrapping
//            modulo 2^ADDR_BITS).
//
// Optional : SRAM_BLOCK_MASTER_BOUNDS_CHECK_EN
//            When defined, a command whose start address is not block
//            aligned, or whose burst would run past the top of the address
//            space, is rejected: it completes at once with done and cmd_err
//            pulsing together, with no SRAM access and no write data taken.
//            When undefined, no checks are made and cmd_err is tied low.
//
// Ports    : clk, n_rst            clock, synchronous active-low reset
//            cmd_valid/cmd_ready   command handshake (ready only when idle)
//            cmd_write             1 = write burst, 0 = read burst
//            cmd_addr              start byte address
//            cmd_len               block count minus one
//            wdata_valid/ready     write block handshake
//            wdata                 write block
//            rdata_valid           one-cycle pulse per read block
//            rdata                 captured read block
//            done                  one-cycle pulse at command completion
//            cmd_err               one-cycle pulse on a rejected command
//            sram_*                SRAM wrapper interface
//
// Revision : 1.0 - initial release
// ============================================================================
module sram_block_master #(
    parameter int ADDR_BITS   = 16,
    parameter int DATA_BYTES  = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      n_rst,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_BITS-1:0]      cmd_addr,
    input  logic [7:0]                cmd_len,

    input  logic                      wdata_valid,
    output logic                      wdata_ready,
    input  logic [8*DATA_BYTES-1:0]   wdata,

    output logic                      rdata_valid,
    output logic [8*DATA_BYTES-1:0]   rdata,

    output logic                      done,
    output logic                      cmd_err,

    output logic                      sram_read_enable,
    output logic                      sram_write_enable,
    output logic [ADDR_BITS-1:0]      sram_address,
    output logic [8*DATA_BYTES-1:0]   sram_write_data,
    input  logic [8*DATA_BYTES-1:0]   sram_read_data
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int DATA_BITS = 8 * DATA_BYTES;

    // The access counter runs 0 .. WAIT_CYCLES-1 inside an access state.
    localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);
    localparam logic [ADDR_BITS-1:0] ADDR_STEP = ADDR_BITS'(DATA_BYTES);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WDATA  = 3'd1;
    localparam logic [2:0] ST_WR_ACC = 3'd2;
    localparam logic [2:0] ST_RD_ACC = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [2:0]           state;
    logic [2:0]           next_state;

    logic [WAIT_W-1:0]    wait_cnt;
    logic [WAIT_W-1:0]    wait_cnt_d;
    logic [7:0]           remaining;
    logic [7:0]           remaining_d;

    logic [ADDR_BITS-1:0] address_d;
    logic [DATA_BITS-1:0] write_data_d;
    logic [DATA_BITS-1:0] rdata_d;
    logic                 read_enable_d;
    logic                 write_enable_d;
    logic                 rdata_valid_d;
    logic                 done_d;

    logic                 acc_last;    // final cycle of the current access
    logic                 last_block;  // no blocks left after this one
    logic                 reject;      // command in IDLE fails the bounds check

    assign acc_last   = (wait_cnt == WAIT_LAST);
    assign last_block = (remaining == 8'd0);

    // Handshake readies decode the state directly so they respond in the
    // same cycle the state is entered.
    assign cmd_ready   = (state == ST_IDLE);
    assign wdata_ready = (state == ST_WDATA);

    // ------------------------------------------------------------------------
    // Optional command bounds check
    // ------------------------------------------------------------------------
`ifdef SRAM_BLOCK_MASTER_BOUNDS_CHECK_EN
    // Burst end is computed with 9 spare bits so that cmd_len = 255 at the
    // top of the space cannot overflow and alias back into range.
    localparam int SPAN_W = ADDR_BITS + 9;

    logic [SPAN_W-1:0] span_end;
    logic              misaligned;
    logic              overrun;
    logic              cmd_err_d;

    always_comb begin
        span_end   = SPAN_W'(cmd_addr)
                   + ((SPAN_W'(cmd_len) + SPAN_W'(1)) * SPAN_W'(DATA_BYTES));
        misaligned = ((cmd_addr % ADDR_STEP) != '0);
        overrun    = (span_end > (SPAN_W'(1) << ADDR_BITS));
        reject     = misaligned || overrun;
    end

    assign cmd_err_d = (state == ST_IDLE) && cmd_valid && reject;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cmd_err <= 1'b0;
        end else begin
            cmd_err <= cmd_err_d;
        end
    end
`else
    assign reject  = 1'b0;
    assign cmd_err = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (reject) begin
                        next_state = ST_DONE;
                    end else if (cmd_write) begin
                        next_state = ST_WDATA;
                    end else begin
                        next_state = ST_RD_ACC;
                    end
                end
            end
            ST_WDATA: begin
                if (wdata_valid) begin
                    next_state = ST_WR_ACC;
                end
            end
            ST_WR_ACC: begin
                if (acc_last) begin
                    next_state = last_block ? ST_DONE : ST_WDATA;
                end
            end
            ST_RD_ACC: begin
                if (acc_last) begin
                    next_state = last_block ? ST_DONE : ST_GAP;
                end
            end
            ST_GAP: begin
                next_state = ST_RD_ACC;
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic
    // Every client/SRAM-facing output is registered, so this process computes
    // the value each register takes at the coming edge. Enables and done are
    // decoded from next_state so they line up exactly with the state they
    // belong to.
    // ------------------------------------------------------------------------
    always_comb begin
        read_enable_d  = (next_state == ST_RD_ACC);
        write_enable_d = (next_state == ST_WR_ACC);
        done_d         = (next_state == ST_DONE);
        rdata_valid_d  = (state == ST_RD_ACC) && acc_last;
        rdata_d        = rdata_valid_d ? sram_read_data : rdata;

        address_d      = sram_address;
        write_data_d   = sram_write_data;
        remaining_d    = remaining;
        wait_cnt_d     = '0;

        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    address_d   = cmd_addr;
                    remaining_d = cmd_len;
                end
            end
            ST_WDATA: begin
                if (wdata_valid) begin
                    write_data_d = wdata;
                end
            end
            ST_WR_ACC, ST_RD_ACC: begin
                if (!acc_last) begin
                    wait_cnt_d = wait_cnt + WAIT_W'(1);
                end else if (!last_block) begin
                    // Address wraps naturally at the register width.
                    address_d   = sram_address + ADDR_STEP;
                    remaining_d = remaining - 8'd1;
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wait_cnt          <= '0;
            remaining         <= 8'd0;
            sram_read_enable  <= 1'b0;
            sram_write_enable <= 1'b0;
            sram_address      <= '0;
            sram_write_data   <= '0;
            rdata             <= '0;
            rdata_valid       <= 1'b0;
            done              <= 1'b0;
        end else begin
            wait_cnt          <= wait_cnt_d;
            remaining         <= remaining_d;
            sram_read_enable  <= read_enable_d;
            sram_write_enable <= write_enable_d;
            sram_address      <= address_d;
            sram_write_data   <= write_data_d;
            rdata             <= rdata_d;
            rdata_valid       <= rdata_valid_d;
            done              <= done_d;
        end
    end

endmodule
`default_nettype wire
